// File: rtl/ibex_pkg.sv
// Shared types for the Ibex-style memory responder.
package ibex_pkg;

    localparam int unsigned WordW = 32;
    localparam int unsigned BeW   = WordW / 8;

    typedef struct packed {
        logic [WordW-1:0] rdata;
        logic             err;
    } mem_rsp_t;

endpackage

// File: rtl/ibex_mem_rsp_fifo.sv
// In-order response FIFO; push and pop are ignored when full and empty respectively.
module ibex_mem_rsp_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  mem_rsp_t entry_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output mem_rsp_t head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_ok, pop_ok;
    mem_rsp_t        store_q [Depth];

    // Wraps at Depth so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = store_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) store_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/ibex_mem_responder.sv
// Simulated data memory for an Ibex-style req/gnt/rvalid port with grant delay and backpressure.
module ibex_mem_responder
    import ibex_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        stall_i
);

    localparam int unsigned IdxW = $clog2(MemWords);

    logic [2:0]       wait_q, wait_d;
    logic [29:0]      word_idx;
    logic [IdxW-1:0]  mem_idx;
    logic             in_range;
    logic             fifo_full, fifo_empty;
    mem_rsp_t         push_entry, head;
    logic [WordW-1:0] mem_q [MemWords];
    logic             unused_addr_bits;

    assign word_idx         = addr_i[31:2];
    assign mem_idx          = word_idx[IdxW-1:0];
    assign in_range         = (32'(word_idx) < 32'(MemWords));
    assign unused_addr_bits = ^addr_i[1:0];

    // Occupancy is judged before any same-cycle pop, so a full FIFO always blocks grant.
    assign gnt_o = req_i && !rst_i && (wait_q == 3'(GntDelay)) && !fifo_full;

    always_comb begin
        wait_d = wait_q;
        if (!req_i || gnt_o) begin
            wait_d = '0;
        end else if (wait_q != 3'(GntDelay)) begin
            wait_d = wait_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) wait_q <= '0;
        else       wait_q <= wait_d;
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && in_range) begin
            for (int b = 0; b < int'(BeW); b++) begin
                if (be_i[b]) mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        push_entry = '0;
        if (!in_range) begin
            push_entry.err = 1'b1;
        end else if (!we_i) begin
            push_entry.rdata = mem_q[mem_idx];
        end
    end

    ibex_mem_rsp_fifo #(
        .Depth (MaxOutstanding)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt_o),
        .entry_i (push_entry),
        .pop_i   (rvalid_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign rvalid_o = !fifo_empty && !stall_i;
    assign rdata_o  = rvalid_o ? head.rdata : '0;
    assign err_o    = rvalid_o ? head.err   : 1'b0;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, randomized run vs queue model.
module tb_ibex_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, we_a, stall_a, gnt_a, rvalid_a, err_a;
    logic [3:0]  be_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, stall_b, gnt_b, rvalid_b, err_b;
    logic [3:0]  be_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ibex_mem_responder #(.MemWords(1024), .GntDelay(0), .MaxOutstanding(2)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .we_i(we_a), .be_i(be_a), .addr_i(addr_a), .wdata_i(wdata_a),
        .rdata_o(rdata_a), .err_o(err_a), .stall_i(stall_a)
    );

    ibex_mem_responder #(.MemWords(64), .GntDelay(3), .MaxOutstanding(2)) dut_dly (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .we_i(we_b), .be_i(be_b), .addr_i(addr_b), .wdata_i(wdata_b),
        .rdata_o(rdata_b), .err_o(err_b), .stall_i(stall_b)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_rsp_t;

    localparam int NVec    = 16;
    localparam int NRand   = 1500;
    localparam int DelayA  = 0;
    localparam int MaxOutA = 2;

    vec_t        vecs [NVec];
    logic [31:0] bp_addrs [3];
    logic [31:0] bp_exp [3];
    logic [31:0] bp_got [$];
    exp_rsp_t    mq [$];
    exp_rsp_t    ent;
    logic [31:0] mm [8];
    logic [31:0] t_rd;
    logic        t_er;
    int          t_gl, t_rl;
    int          ng, first_rv, third_g, g_cyc, rv_cyc, waitc;
    logic        exp_gnt, exp_rv;
    logic [29:0] idx;
    int          sel;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // One complete transaction on the delay-0 instance, returning latencies and response.
    task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int glat, output int rlat);
        rd = '0; er = 1'b0; glat = -1; rlat = -1;
        @(negedge clk);
        req_a = 1'b1; we_a = we; be_a = be; addr_a = addr; wdata_a = wd; stall_a = 1'b0;
        for (int c = 0; c < 8 && glat < 0; c++) begin
            #1;
            if (gnt_a) glat = c;
            @(negedge clk);
        end
        req_a = 1'b0; we_a = ~we; be_a = ~be; addr_a = ~addr; wdata_a = ~wd;
        for (int c = 1; c < 8 && rlat < 0; c++) begin
            #1;
            if (rvalid_a) begin
                rlat = c; rd = rdata_a; er = err_a;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_1000, 32'h1234_5678, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[9]  = '{1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[10] = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[12] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[13] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[14] = '{1'b1, 4'hF, 32'h0000_0008, 32'h5555_AAAA, 32'h0,         1'b0};
        vecs[15] = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};
        bp_addrs[0] = 32'h10; bp_addrs[1] = 32'h20; bp_addrs[2] = 32'h0;
        bp_exp[0] = 32'hDEAD_BEEF; bp_exp[1] = 32'h11BB_33DD; bp_exp[2] = 32'h0BAD_F00D;

        // Reset with a request pending: grant must stay low, outputs idle afterwards.
        rst = 1'b1; req_a = 1'b1; we_a = 1'b0; be_a = 4'hF; addr_a = '0; wdata_a = '0; stall_a = 1'b0;
        req_b = 1'b0; we_b = 1'b0; be_b = 4'hF; addr_b = '0; wdata_b = '0; stall_b = 1'b0;
        @(negedge clk);
        #1 check("gnt_in_reset", 32'(gnt_a), 32'h0);
        @(negedge clk);
        rst = 1'b0; req_a = 1'b0;
        #1;
        check("reset_rvalid", 32'(rvalid_a), 32'h0);
        check("reset_rdata", rdata_a, 32'h0);
        check("reset_err", 32'(err_a), 32'h0);

        for (int i = 0; i < NVec; i++) begin
            txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, t_rd, t_er, t_gl, t_rl);
            check($sformatf("vec%0d_rdata", i), t_rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(t_er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_gnt_lat", i), 32'(t_gl), 32'd0);
            check($sformatf("vec%0d_rvalid_lat", i), 32'(t_rl), 32'd1);
        end

        // Backpressure: three reads against a two-deep FIFO while stalled.
        @(negedge clk);
        stall_a = 1'b1; req_a = 1'b1; we_a = 1'b0; addr_a = bp_addrs[0];
        ng = 0; first_rv = -1; third_g = -1;
        for (int c = 0; c < 16; c++) begin
            if (c == 6) stall_a = 1'b0;
            #1;
            if (rvalid_a) begin
                bp_got.push_back(rdata_a);
                if (first_rv < 0) first_rv = c;
            end
            if (gnt_a) begin
                if (ng == 2) third_g = c;
                ng++;
            end
            if (c == 5) begin
                check("bp_grants_while_stalled", 32'(ng), 32'd2);
                check("bp_rvalid_while_stalled", 32'(bp_got.size()), 32'd0);
            end
            @(negedge clk);
            if (ng >= 3) req_a = 1'b0;
            else         addr_a = bp_addrs[ng];
        end
        check("bp_first_rvalid_cycle", 32'(first_rv), 32'd6);
        check("bp_third_grant_not_early", 32'(third_g >= first_rv && third_g >= 0), 32'd1);
        check("bp_resp_count", 32'(bp_got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < bp_got.size()) check($sformatf("bp_resp%0d", i), bp_got[i], bp_exp[i]);
        end

        // Grant delay of three cycles on the second instance.
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'h40;
        g_cyc = -1; rv_cyc = -1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (gnt_b && g_cyc < 0) g_cyc = c;
            if (rvalid_b && rv_cyc < 0) begin
                rv_cyc = c;
                check("dly_err", 32'(err_b), 32'h0);
            end
            @(negedge clk);
            if (g_cyc >= 0) req_b = 1'b0;
        end
        check("dly_gnt_cycle", 32'(g_cyc), 32'd3);
        check("dly_rvalid_cycle", 32'(rv_cyc), 32'd4);

        // Reset with two pending responses; a write during reset must be dropped.
        @(negedge clk);
        stall_a = 1'b1; req_a = 1'b1; we_a = 1'b0; addr_a = 32'h10; ng = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (gnt_a) ng++;
            @(negedge clk);
        end
        check("rst_pending_grants", 32'(ng), 32'd2);
        rst = 1'b1; we_a = 1'b1; addr_a = 32'h8; wdata_a = 32'hBAD0_BAD0; be_a = 4'hF;
        #1 check("gnt_during_reset", 32'(gnt_a), 32'h0);
        @(negedge clk);
        rst = 1'b0; req_a = 1'b0; we_a = 1'b0; stall_a = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("post_rst_rvalid%0d", c), 32'(rvalid_a), 32'h0);
            check($sformatf("post_rst_rdata%0d", c), rdata_a, 32'h0);
            @(negedge clk);
        end
        txn(1'b0, 4'hF, 32'h8, 32'h0, t_rd, t_er, t_gl, t_rl);
        check("post_rst_read8", t_rd, 32'h5555_AAAA);
        check("post_rst_read8_err", 32'(t_er), 32'h0);

        // Randomized run: preload words 0..7, then free-running traffic vs queue model.
        for (int k = 0; k < 8; k++) begin
            mm[k] = $urandom;
            txn(1'b1, 4'hF, 32'(k * 4), mm[k], t_rd, t_er, t_gl, t_rl);
            check($sformatf("preload%0d_gnt_lat", k), 32'(t_gl), 32'd0);
        end
        waitc = 0;
        for (int i = 0; i < NRand; i++) begin
            @(negedge clk);
            req_a   = (i >= NRand - 4) ? 1'b0 : ($urandom_range(0, 9) < 6);
            stall_a = (i >= NRand - 4) ? 1'b0 : ($urandom_range(0, 9) < 3);
            we_a    = 1'($urandom_range(0, 1));
            be_a    = 4'($urandom);
            wdata_a = $urandom;
            sel     = int'($urandom_range(0, 15));
            if (sel < 14)       idx = 30'(sel % 8);
            else if (sel == 14) idx = 30'(1024 + $urandom_range(0, 99));
            else                idx = 30'h3FFF_FFFF;
            addr_a = {idx, 2'($urandom)};
            #1;
            exp_gnt = req_a && (waitc == DelayA) && (mq.size() < MaxOutA);
            exp_rv  = (mq.size() > 0) && !stall_a;
            check("rnd_gnt", 32'(gnt_a), 32'(exp_gnt));
            check("rnd_rvalid", 32'(rvalid_a), 32'(exp_rv));
            check("rnd_rdata", rdata_a, exp_rv ? mq[0].rdata : 32'h0);
            check("rnd_err", 32'(err_a), exp_rv ? 32'(mq[0].err) : 32'h0);
            if (exp_rv) void'(mq.pop_front());
            if (exp_gnt) begin
                if (idx >= 30'd1024) begin
                    ent.rdata = '0; ent.err = 1'b1;
                end else if (we_a) begin
                    ent.rdata = '0; ent.err = 1'b0;
                    for (int b = 0; b < 4; b++) begin
                        if (be_a[b]) mm[idx[2:0]][8*b +: 8] = wdata_a[8*b +: 8];
                    end
                end else begin
                    ent.rdata = mm[idx[2:0]]; ent.err = 1'b0;
                end
                mq.push_back(ent);
            end
            if (!req_a || exp_gnt) waitc = 0;
            else if (waitc < DelayA) waitc++;
        end
        check("rnd_drained", 32'(mq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibex_mem_responder.md
IBEX_MEM_RESPONDER -- requirements
Module: ibex_mem_responder

Interface
REQ-001 SHALL have parameter MemWords, default 1024, number of 32-bit words in backing store (power of two, >=2).
REQ-002 SHALL have parameter GntDelay, default 0, cycles req_i must be held before gnt_o (range 0..7).
REQ-003 SHALL have parameter MaxOutstanding, default 2, granted-but-unanswered request limit (range 1..8).
REQ-004 Port clk_i, input, 1, single clock; all logic on rising edge.
REQ-005 Port rst_i, input, 1, reset, synchronous and active-high.
REQ-006 Port req_i, input, 1, request from core.
REQ-007 Port gnt_o, output, 1, request accepted this cycle.
REQ-008 Port rvalid_o, output, 1, response valid this cycle.
REQ-009 Port we_i, input, 1, write when high, read when low.
REQ-010 Port be_i, input, 4, byte enables for writes.
REQ-011 Port addr_i, input, 32, byte address; bits [1:0] ignored.
REQ-012 Port wdata_i, input, 32, write data.
REQ-013 Port rdata_o, output, 32, read data of response.
REQ-014 Port err_o, output, 1, response carries bus error.
REQ-015 Port stall_i, input, 1, bench control; high suppresses rvalid_o.

Function
REQ-016 SHALL count consecutive cycles with req_i high and gnt_o low in a 3-bit wait counter; counter clears on grant or when req_i low.
REQ-017 SHALL assert gnt_o (combinational) iff req_i high, wait counter == GntDelay, and outstanding count < MaxOutstanding (same-cycle pop not credited).
REQ-018 SHALL sample we_i, be_i, addr_i, wdata_i only in the grant cycle; inputs outside grant cycles have no effect.
REQ-019 SHALL compute word index = addr_i[31:2]; index >= MemWords is an error access.
REQ-020 On granted in-range write: SHALL update only bytes with be_i set at end of grant cycle; response rdata 0, err 0.
REQ-021 On granted in-range read: SHALL capture store word at grant cycle (reflecting all earlier-granted writes) as response data, err 0.
REQ-022 On granted error access: SHALL not modify store; response rdata 0, err 1.
REQ-023 SHALL push each granted response into an in-order response FIFO of depth MaxOutstanding at end of grant cycle.
REQ-024 rvalid_o SHALL equal (FIFO not empty) and not stall_i; rdata_o/err_o SHALL show FIFO head when rvalid_o high, else 0.
REQ-025 SHALL pop FIFO head in every cycle rvalid_o is high; earliest rvalid_o is cycle after grant (latency 1).
REQ-026 Simultaneous push and pop SHALL leave outstanding count unchanged; responses SHALL return in grant order.
REQ-027 With FIFO full, gnt_o SHALL stay low regardless of wait counter; wait counter saturates at GntDelay.

Reset
REQ-028 With rst_i high at a clock edge: gnt_o 0, rvalid_o 0, rdata_o 0, err_o 0 from next cycle; FIFO emptied; wait counter 0.
REQ-029 Reset mid-transaction SHALL discard all pending responses; no rvalid_o for them after reset.
REQ-030 Backing store contents SHALL NOT be reset; a write granted in the reset cycle SHALL be dropped.
REQ-031 gnt_o SHALL be forced low while rst_i high.

Structure
REQ-032 Response entry typedef (rdata 32, err 1) SHALL live in shared package ibex_pkg as mem_rsp_t.
REQ-033 Response FIFO SHALL be a sub-module ibex_mem_rsp_fifo (parameter Depth, push/pop/full/empty/head).
REQ-034 Backing store SHALL be an inferred array with per-byte write enables, no reset.

Verification
REQ-035 GntDelay=0: write addr 0x10 data 0xDEADBEEF be 0xF, then read 0x10 -> gnt same cycle as req, rvalid 1 cycle after each grant, rdata 0xDEADBEEF err 0.
REQ-036 Byte enables: store 0x11223344 at 0x20, write 0xAABBCCDD be 0x5, read -> rdata 0x11BB33DD.
REQ-037 Error: MemWords=1024, read addr 0x1000 -> err_o 1, rdata 0; subsequent read 0x0 err 0, store unchanged.
REQ-038 Backpressure: MaxOutstanding=2, stall_i high, 3 back-to-back reads -> 2 grants, third req held without gnt; drop stall -> rvalid 2 cycles in order, third grant in first rvalid cycle or later.
REQ-039 GntDelay=3: req held from cycle 0 -> gnt_o first in cycle 3; rvalid cycle 4.
REQ-040 Reset with 2 pending responses under stall_i -> no rvalid after reset; prior write at 0x8 still readable as written.
